// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B4 pipelined initiator: one valid/ready request
// becomes one bus cycle with stall, err/ack/rty handling and a per-attempt timeout.
module wb_initiator #(
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic        wb_stall_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(RETRY_MAX);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RETRY} state_t;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rty_cnt_q, rty_cnt_d;

  logic          sample;
  logic          finish;
  logic [1:0]    fin_status;
  logic [31:0]   fin_dat;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    tmo_d        = tmo_q;
    rty_cnt_d    = rty_cnt_q;
    finish       = 1'b0;
    fin_status   = 2'b00;
    fin_dat      = 32'h0;
    // A stalled strobe has not been taken, so its terminations do not count yet.
    sample = ((state_q == S_STROBE) && !wb_stall_i) || (state_q == S_WAIT);

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          we_d        = req_we_i;
          adr_d       = req_adr_i;
          dat_d       = req_dat_i;
          sel_d       = req_sel_i;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          req_ready_d = 1'b0;
          tmo_d       = '0;
          rty_cnt_d   = '0;
          state_d     = S_STROBE;
        end
      end
      S_STROBE, S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (sample && wb_err_i) begin
          finish     = 1'b1;
          fin_status = 2'b01;
        end else if (sample && wb_ack_i) begin
          finish  = 1'b1;
          fin_dat = we_q ? 32'h0 : wb_dat_i;
        end else if (sample && wb_rty_i) begin
          if (rty_cnt_q != RTY_LAST) begin
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            rty_cnt_d = rty_cnt_q + RW'(1);
            state_d   = S_RETRY;
          end else begin
            finish     = 1'b1;
            fin_status = 2'b10;
          end
        end else if (tmo_q == TMO_LAST) begin
          finish     = 1'b1;
          fin_status = 2'b11;
        end else if (sample) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_RETRY: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_STROBE;
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      cyc_d        = 1'b0;
      stb_d        = 1'b0;
      rsp_valid_d  = 1'b1;
      rsp_dat_d    = fin_dat;
      rsp_status_d = fin_status;
      req_ready_d  = 1'b1;
      state_d      = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'h0;
      dat_q        <= 32'h0;
      sel_q        <= 4'h0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= 32'h0;
      rsp_status_q <= 2'b00;
      tmo_q        <= '0;
      rty_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      tmo_q        <= tmo_d;
      rty_cnt_q    <= rty_cnt_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;

endmodule
